slot_mem_responder: RTL and testbench

SLOT_MEM_RESPONDER -- requirements
Module: slot_mem_responder

---
 rtl/mem_pkg.sv | 10 +
 rtl/slot_mem.sv | 18 +
 rtl/slot_mem_responder.sv | 75 +++++++
 tb/tb_slot_mem_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared slot-memory constants, responder state encoding and log2 helper
package mem_pkg;
  localparam int WORDSZ_BYTES_DEF = 4;
  typedef enum logic [1:0] {UNINIT, IDLE, ACCESS, RESP} state_t;
  function automatic int log2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/slot_mem.sv
// slot_mem: single-port synchronous SLOTS x 32 storage (clk; en/we/addr/wdata in; rdata registered out), no reset
module slot_mem import mem_pkg::*; #(
  parameter int SLOTS = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [log2(SLOTS)-1:0]   addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] mem [SLOTS];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/slot_mem_responder.sv
// slot_mem_responder: req/rsp slot memory with base-pointer reverse translation (base load, request in, response with rdata/vptr/err out)
module slot_mem_responder import mem_pkg::*; #(
  parameter int MEM_SLOTS_COUNT = 32,
  parameter int WORDSZ_BYTES    = WORDSZ_BYTES_DEF
) (
  input  logic                             _clk,
  input  logic                             _reset_n,
  input  logic                             _base_vld,
  input  logic [31:0]                      _base_vptr,
  input  logic                             _req_vld,
  output logic                             req_rdy_,
  input  logic                             _req_we,
  input  logic [log2(MEM_SLOTS_COUNT)-1:0] _req_slot,
  input  logic [31:0]                      _req_wdata,
  output logic                             rsp_vld_,
  input  logic                             _rsp_rdy,
  output logic [31:0]                      rsp_rdata_,
  output logic [31:0]                      rsp_vptr_,
  output logic                             rsp_err_
);
  localparam int SW = log2(MEM_SLOTS_COUNT);
  state_t state, state_nx;
  logic [31:0] base_q, wdata_q, mem_rdata;
  logic [SW-1:0] slot_q;
  logic we_q, err_q, loaded, accept, base_ld;
  assign req_rdy_ = state == UNINIT || state == IDLE;
  assign accept   = _req_vld & req_rdy_;
  assign base_ld  = _base_vld & req_rdy_;
  always_ff @(posedge _clk or negedge _reset_n)
    if (!_reset_n) begin
      state   <= UNINIT;
      base_q  <= '0;
      loaded  <= 1'b0;
      slot_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (base_ld) begin
        base_q <= _base_vptr;
        loaded <= 1'b1;
      end
      if (accept) begin
        slot_q  <= _req_slot;
        we_q    <= _req_we;
        wdata_q <= _req_wdata;
        // a base loaded on the accept edge counts as loaded for this request
        err_q   <= !(loaded | _base_vld);
      end
    end
  always_comb begin
    state_nx = state;
    case (state)
      UNINIT, IDLE: state_nx = accept ? ACCESS : base_ld ? IDLE : state;
      ACCESS:       state_nx = RESP;
      RESP:         state_nx = _rsp_rdy ? (loaded ? IDLE : UNINIT) : RESP;
      default:      state_nx = UNINIT;
    endcase
  end
  always_comb begin
    rsp_vld_   = state == RESP;
    rsp_err_   = rsp_vld_ & err_q;
    rsp_rdata_ = (rsp_vld_ && !err_q) ? (we_q ? wdata_q : mem_rdata) : '0;
    rsp_vptr_  = (rsp_vld_ && !err_q) ? base_q + 32'(slot_q) * 32'(WORDSZ_BYTES) : '0;
  end
  slot_mem #(.SLOTS(MEM_SLOTS_COUNT)) u_mem (
    .clk   (_clk),
    .en    (state == ACCESS && !err_q),
    .we    (we_q),
    .addr  (slot_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );
endmodule

// File: tb/tb_slot_mem_responder.sv
// tb_slot_mem_responder: table-driven plus scoreboard bench for slot_mem_responder
module tb_slot_mem_responder;
  logic _clk, _reset_n, _base_vld, _req_vld, req_rdy_, _req_we, rsp_vld_, _rsp_rdy, rsp_err_;
  logic [31:0] _base_vptr, _req_wdata, rsp_rdata_, rsp_vptr_;
  logic [4:0] _req_slot;
  int tests = 0, fails = 0;
  typedef struct {
    logic we; logic [4:0] slot; logic [31:0] wdata; logic bvld; logic [31:0] base;
    logic [31:0] e_rdata; logic [31:0] e_vptr; logic e_err;
  } vec_t;
  typedef struct { logic [31:0] rdata; logic [31:0] vptr; logic err; } exp_t;
  exp_t q[$];
  vec_t tbl[11];

  slot_mem_responder dut (
    ._clk(_clk), ._reset_n(_reset_n), ._base_vld(_base_vld), ._base_vptr(_base_vptr),
    ._req_vld(_req_vld), .req_rdy_(req_rdy_), ._req_we(_req_we), ._req_slot(_req_slot),
    ._req_wdata(_req_wdata), .rsp_vld_(rsp_vld_), ._rsp_rdy(_rsp_rdy), .rsp_rdata_(rsp_rdata_),
    .rsp_vptr_(rsp_vptr_), .rsp_err_(rsp_err_)
  );

  initial begin
    _clk = 0;
    forever #5 _clk = ~_clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic we, input logic [4:0] slot, input logic [31:0] wd,
                           input logic bvld, input logic [31:0] base,
                           input logic [31:0] er, input logic [31:0] ev, input logic ee);
    chk("req_rdy_before_accept", req_rdy_, 1);
    _req_vld = 1; _req_we = we; _req_slot = slot; _req_wdata = wd;
    _base_vld = bvld; _base_vptr = base;
    q.push_back('{er, ev, ee});
    @(posedge _clk);
    @(negedge _clk);
    _req_vld = 0; _base_vld = 0;
  endtask

  task automatic await_rsp(input int hold);
    int n = 1;
    exp_t e;
    while (!rsp_vld_ && n < 8) begin
      chk("idle_rdata_zero", rsp_rdata_, 0);
      chk("idle_vptr_zero", rsp_vptr_, 0);
      chk("idle_err_zero", rsp_err_, 0);
      @(negedge _clk);
      n++;
    end
    chk("latency_edges", n, 2);
    if (q.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
      return;
    end
    e = q.pop_front();
    chk("rsp_rdata", rsp_rdata_, e.rdata);
    chk("rsp_vptr", rsp_vptr_, e.vptr);
    chk("rsp_err", rsp_err_, e.err);
    repeat (hold) begin
      _base_vld = 1; _base_vptr = 32'h2000;
      @(negedge _clk);
      chk("hold_vld", rsp_vld_, 1);
      chk("hold_req_rdy", req_rdy_, 0);
      chk("hold_rdata", rsp_rdata_, e.rdata);
      chk("hold_vptr", rsp_vptr_, e.vptr);
      chk("hold_err", rsp_err_, e.err);
    end
    _base_vld = 0;
  endtask

  task automatic release_rsp();
    _rsp_rdy = 1;
    @(negedge _clk);
    _rsp_rdy = 0;
    chk("rsp_vld_after_release", rsp_vld_, 0);
  endtask

  task automatic pulse_reset();
    _reset_n = 0;
    #1;
    chk("reset_rsp_vld", rsp_vld_, 0);
    chk("reset_req_rdy", req_rdy_, 1);
    chk("reset_rdata", rsp_rdata_, 0);
    chk("reset_vptr", rsp_vptr_, 0);
    chk("reset_err", rsp_err_, 0);
    @(negedge _clk);
    _reset_n = 1;
  endtask

  initial begin
    _reset_n = 0; _base_vld = 0; _base_vptr = 0; _req_vld = 0; _req_we = 0;
    _req_slot = 0; _req_wdata = 0; _rsp_rdy = 0;
    tbl[0]  = '{0,  3, 32'h0,        0, 32'h0,        32'h0,        32'h0,        1};
    tbl[1]  = '{1,  5, 32'hDEADBEEF, 1, 32'h1000,     32'hDEADBEEF, 32'h1014,     0};
    tbl[2]  = '{0,  5, 32'h0,        0, 32'h0,        32'hDEADBEEF, 32'h1014,     0};
    tbl[3]  = '{1,  0, 32'h12345678, 0, 32'h0,        32'h12345678, 32'h1000,     0};
    tbl[4]  = '{1, 31, 32'hA5A5A5A5, 0, 32'h0,        32'hA5A5A5A5, 32'h107C,     0};
    tbl[5]  = '{0,  0, 32'h0,        0, 32'h0,        32'h12345678, 32'h1000,     0};
    tbl[6]  = '{0, 31, 32'h0,        1, 32'hFFFFFFF8, 32'hA5A5A5A5, 32'h00000074, 0};
    tbl[7]  = '{1,  3, 32'hCAFEF00D, 0, 32'h0,        32'hCAFEF00D, 32'h00000004, 0};
    tbl[8]  = '{0,  3, 32'h0,        0, 32'h0,        32'hCAFEF00D, 32'h00000004, 0};
    tbl[9]  = '{1,  7, 32'h11112222, 1, 32'h1000,     32'h11112222, 32'h101C,     0};
    tbl[10] = '{1,  1, 32'h0BADC0DE, 0, 32'h0,        32'h0BADC0DE, 32'h1004,     0};
    #1;
    chk("por_rsp_vld", rsp_vld_, 0);
    chk("por_req_rdy", req_rdy_, 1);
    chk("por_rdata", rsp_rdata_, 0);
    chk("por_vptr", rsp_vptr_, 0);
    chk("por_err", rsp_err_, 0);
    @(negedge _clk);
    _reset_n = 1;
    for (int i = 0; i < 11; i++) begin
      drive_req(tbl[i].we, tbl[i].slot, tbl[i].wdata, tbl[i].bvld, tbl[i].base,
                tbl[i].e_rdata, tbl[i].e_vptr, tbl[i].e_err);
      await_rsp(0);
      release_rsp();
    end
    // stall in RESP with an ignored base load, then a request held across the release edge
    drive_req(0, 5, 0, 0, 0, 32'hDEADBEEF, 32'h1014, 0);
    await_rsp(4);
    _rsp_rdy = 1; _req_vld = 1; _req_we = 0; _req_slot = 0;
    @(negedge _clk);
    _rsp_rdy = 0;
    chk("release_edge_no_accept_vld", rsp_vld_, 0);
    chk("release_edge_no_accept_rdy", req_rdy_, 1);
    q.push_back('{32'h12345678, 32'h1000, 0});
    @(posedge _clk);
    @(negedge _clk);
    _req_vld = 0;
    await_rsp(0);
    release_rsp();
    // reset during ACCESS aborts the pending write and drops the base
    drive_req(1, 7, 32'h99999999, 0, 0, 32'h99999999, 32'h101C, 0);
    chk("in_access_rsp_vld", rsp_vld_, 0);
    void'(q.pop_back());
    pulse_reset();
    @(negedge _clk);
    chk("post_abort_rsp_vld", rsp_vld_, 0);
    drive_req(0, 7, 0, 0, 0, 32'h0, 32'h0, 1);
    await_rsp(0);
    release_rsp();
    drive_req(0, 7, 0, 1, 32'h1000, 32'h11112222, 32'h101C, 0);
    await_rsp(0);
    release_rsp();
    // base load and request on the same edge in UNINIT
    pulse_reset();
    drive_req(0, 1, 0, 1, 32'h3000, 32'h0BADC0DE, 32'h3004, 0);
    await_rsp(0);
    release_rsp();
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
